// File: rtl/light_part_read_dispatch.sv
// Light-part read dispatch: buffers flow keys, picks a RAM bank per key and issues
// one-cycle reads while forwarding {timestamp, flow ID} to the compare stage.
module light_part_read_dispatch #(
    parameter int KEY_W     = 96,
    parameter int FLOW_W    = 64,
    parameter int ADDR_W    = 16,
    parameter int NUM_BANKS = 8,
    parameter int BANK_W    = 3,
    parameter int TS_W      = 64,
    parameter int FIFO_AW   = 9,
    parameter int AF_THRESH = 256
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        key_in_wr,
    input  logic [KEY_W-1:0]            key_in,
    output logic                        key_in_alf,
    input  logic                        bank_mode,
    input  logic                        issue_en,
    input  logic                        flush,
    output logic [NUM_BANKS-1:0]        rden,
    output logic [NUM_BANKS*ADDR_W-1:0] rdaddr,
    output logic                        out_wr,
    output logic [TS_W+FLOW_W-1:0]      out_data,
    input  logic                        out_alf,
    output logic [31:0]                 drop_cnt,
    output logic [31:0]                 issue_cnt
);

    // state | meaning
    // IDLE  | no key in flight; rden/out_wr low
    // RUN   | key popped on the previous edge is being issued this cycle

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0] AF_LVL   = (FIFO_AW+1)'(AF_THRESH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;

    logic [KEY_W-1:0]  mem [DEPTH];
    logic [FIFO_AW:0]  wr_ptr;
    logic [FIFO_AW:0]  rd_ptr;
    logic [FIFO_AW:0]  usedw;
    logic              full;
    logic              empty;
    logic              go;
    logic              wr_ok;
    logic              drop;
    logic [TS_W-1:0]   ts;

    logic [KEY_W-1:0]  head;
    logic [FLOW_W-1:0] head_flow;
    logic [ADDR_W-1:0] head_addr;
    logic [BANK_W-1:0] head_lo;
    logic [BANK_W-1:0] head_hi;
    logic [BANK_W-1:0] head_bank;
    logic              unused_head_bits;

    assign usedw      = wr_ptr - rd_ptr;
    assign full       = (usedw == FULL_LVL);
    assign empty      = (usedw == '0);
    assign key_in_alf = (usedw >= AF_LVL);

    assign go    = !empty && !out_alf && issue_en && !flush;
    assign wr_ok = key_in_wr && !full && !flush;
    // A write against a full FIFO is lost even if a pop frees a slot this cycle.
    assign drop  = key_in_wr && full && !flush;

    assign head      = mem[rd_ptr[FIFO_AW-1:0]];
    assign head_flow = head[KEY_W-1 -: FLOW_W];
    assign head_addr = head[KEY_W-1 -: ADDR_W];
    assign head_lo   = head[BANK_W-1:0];
    assign head_hi   = head[2*BANK_W-1:BANK_W];
    assign head_bank = bank_mode ? (head_lo ^ head_hi) : head_lo;

    // Middle key bits are stored but only a subset feeds the outputs.
    assign unused_head_bits = ^head;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= key_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (go) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts <= '0;
        end else begin
            ts <= ts + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 32'hFFFF_FFFF)) begin
            drop_cnt <= drop_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rden      <= '0;
            rdaddr    <= '0;
            out_wr    <= 1'b0;
            out_data  <= '0;
            issue_cnt <= '0;
        end else begin
            if (state == RUN) begin
                issue_cnt <= issue_cnt + 32'd1;
            end
            // Same pop decision in both states: RUN can chain straight into the next key.
            if (go) begin
                state    <= RUN;
                out_wr   <= 1'b1;
                out_data <= {ts, head_flow};
                for (int b = 0; b < NUM_BANKS; b++) begin
                    rden[b] <= (head_bank == BANK_W'(b));
                    if (head_bank == BANK_W'(b)) begin
                        rdaddr[b*ADDR_W +: ADDR_W] <= head_addr;
                    end
                end
            end else begin
                state  <= IDLE;
                out_wr <= 1'b0;
                rden   <= '0;
            end
        end
    end

endmodule
